shift_add_multiplier_ctrl: RTL and testbench
============================================

# shift_add_multiplier_ctrl

Sequential unsigned shift-and-add multiplier with its own control sequencer. It accepts two WORD_LENGTH-bit operands on a start/ready handshake. It iterates one multiplier bit per clock using a left-shifting multiplicand register and a right-shifting multiplier register, then presents a 2·WORD_LENGTH-bit product with a one-cycle done pulse. It is the control layer that sequences the shift-left register datapath for the arithmetic practice units.

## Interface
- WORD_LENGTH, default 8: operand width in bits, ≥ 2.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a multiplication; sampled only while ready=1.
- multiplicand  input  WORD_LENGTH  operand A, unsigned; captured on accepted start.
- multiplier  input  WORD_LENGTH  operand B, unsigned; captured on accepted start.
- ready  output  1  high in IDLE; a start is accepted on any clock edge where ready=1 and start=1.
- done  output  1  one-cycle pulse, high while in DONE.
- product  output  2·WORD_LENGTH  registered result; holds its value until the next completion.

## Operation
- State machine with states IDLE, RUN and DONE.
  - IDLE: ready=1. On start=1:
    - mcand_reg ← zero-extended multiplicand (2·WORD_LENGTH bits).
    - mplier_reg ← multiplier.
    - acc ← 0, count ← 0.
    - Next state is RUN.
  - RUN: every cycle:
    - If mplier_reg[0]=1, acc ← acc + mcand_reg.
    - mcand_reg ← mcand_reg << 1, with zero fill.
    - mplier_reg ← mplier_reg >> 1, with zero fill.
    - count ← count + 1.
    - When count = WORD_LENGTH−1, the same edge also loads product ← final acc value (including this cycle's add) and moves to DONE.
  - DONE: done=1 and ready=0. Unconditionally returns to IDLE on the next edge.
- Fixed iteration count of WORD_LENGTH. No early termination on a zero multiplier.
- Arithmetic is unsigned, with acc and product 2·WORD_LENGTH bits wide; overflow is impossible by construction.
- count width is $clog2(WORD_LENGTH+1).
- start while in RUN or DONE is ignored, with no queuing. Operand changes after acceptance have no effect.
- If start is held high continuously, a new operation is accepted on every return to IDLE (back-to-back).
- Reset (asynchronous, any state, including mid-RUN) forces the following; the in-flight operation is discarded:
  - state = IDLE
  - acc, mcand_reg, mplier_reg, count, product = 0
  - done = 0
  - ready = 1 (decoded from state)

## Timing
- ready and done are decoded combinationally from the state register only, with no input-to-output combinational path.
- Start accepted at edge k:
  - RUN occupies edges k+1 … k+WORD_LENGTH.
  - product is updated at edge k+WORD_LENGTH.
  - done is high from edge k+WORD_LENGTH to edge k+WORD_LENGTH+1.
  - ready returns high after edge k+WORD_LENGTH+1.
- Start-to-done latency is WORD_LENGTH cycles; throughput is one result per WORD_LENGTH+2 cycles.
- product is stable and valid from the done cycle until the next done. It is 0 before the first completion.

## Structure
- Shared package mult_pkg holds:
  - typedef enum logic [1:0] mult_state_t {IDLE, RUN, DONE}.
  - The default WORD_LENGTH constant, used by the bench as well.
- One sub-module is natural: shift_left_load_register, parameterized by width.
  - Inputs: clk, reset, load, shift_en, data_in.
  - Behaviour: load takes priority over shift; shift is left by 1 with zero fill; async active-low clear.
  - Instantiated for mcand_reg.
- The FSM, mplier_reg, acc and count live in the top module.

## Test plan
(All scenarios use WORD_LENGTH=8.)
- Reset: hold reset=0 across edges → ready=1, done=0, product=0. Release reset with start=0 → outputs unchanged.
- 13×11 with a one-cycle start → done rises exactly 8 cycles after acceptance, product=143 (16'h008F). ready is low for 9 cycles, then high.
- Corners:
  - 255×255 → product=65025 (16'hFE01).
  - 0×200 → 0.
  - 1×255 → 255.
  - product holds each value until the next done.
- start with 3×3 asserted during RUN of 7×6 → ignored; product=42 and no second done follows.
- Reset pulse on the 4th RUN cycle of 200×100 → immediately ready=1, product=0, no done. The next operation, 9×9, yields 81 with normal latency.
- start held high with operands 2×3, changed to 4×5 after the first acceptance → done pulses 10 cycles apart, product=6 then 20.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Default operand width, shared by the design and its bench.
  localparam int MULT_WORD_LENGTH = 8;

endpackage

// File: rtl/shift_left_load_register.sv
// Loadable left-shift register with zero fill; a load wins over a shift.
module shift_left_load_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_reg;

  // Hold, load, or shift left by one, with an asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= data_in;
    end else if (shift_en) begin
      data_reg <= {data_reg[WIDTH-2:0], 1'b0};
    end
  end

  assign data_out = data_reg;

endmodule

// File: rtl/shift_add_multiplier_ctrl.sv
// Unsigned shift-and-add multiplier: one multiplier bit per clock,
// a fixed WORD_LENGTH iterations, then a one-cycle done pulse.
module shift_add_multiplier_ctrl
  import mult_pkg::*;
#(
  parameter int WORD_LENGTH = MULT_WORD_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     multiplicand,
  input  logic [WORD_LENGTH-1:0]     multiplier,
  output logic                       ready,
  output logic                       done,
  output logic [2*WORD_LENGTH-1:0]   product
);

  localparam int PW = 2 * WORD_LENGTH;
  localparam int CW = $clog2(WORD_LENGTH + 1);

  mult_state_t            state_reg;
  mult_state_t            state_next;
  logic [PW-1:0]          mcand_reg;
  logic [PW-1:0]          acc_reg;
  logic [PW-1:0]          acc_next;
  logic [PW-1:0]          product_reg;
  logic [WORD_LENGTH-1:0] mplier_reg;
  logic [CW-1:0]          count_reg;
  logic                   last_iter;
  logic                   load_op;
  logic                   shift_op;

  // Multiplicand is zero-extended so it can shift up into the product width.
  shift_left_load_register #(
    .WIDTH (PW)
  ) u_mcand_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load_op),
    .shift_en (shift_op),
    .data_in  ({{WORD_LENGTH{1'b0}}, multiplicand}),
    .data_out (mcand_reg)
  );

  // Conditional add of the current multiplicand weight.
  always_comb begin
    acc_next = acc_reg;
    if (mplier_reg[0]) begin
      acc_next = acc_reg + mcand_reg;
    end
  end

  assign last_iter = (count_reg == CW'(WORD_LENGTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control decode; ready/done depend on state only.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    done       = 1'b0;
    load_op    = 1'b0;
    shift_op   = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load_op    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        shift_op = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Multiplier shift, accumulator, iteration count and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mplier_reg  <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else if (load_op) begin
      mplier_reg <= multiplier;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else if (shift_op) begin
      acc_reg    <= acc_next;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + CW'(1);
      if (last_iter) begin
        product_reg <= acc_next;
      end
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
// Directed bench for the shift-and-add multiplier (WORD_LENGTH = 8).
module tb_shift_add_multiplier_ctrl;
  import mult_pkg::*;

  localparam int W = MULT_WORD_LENGTH;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           ready;
  logic           done;
  logic [2*W-1:0] product;

  int n_compared   = 0;
  int n_mismatched = 0;
  int prev_product = 0;

  shift_add_multiplier_ctrl #(
    .WORD_LENGTH (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_dones(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
  endtask

  // One full operation; optionally pokes start with 3x3 during RUN.
  task automatic run_op(input int a, input int b, input bit inject);
    int lat;
    int ready_low;
    int exp_p;
    exp_p = a * b;
    check("ready_before", ready, 1);
    multiplicand = W'(a);
    multiplier   = W'(b);
    start        = 1'b1;
    tick();
    start     = 1'b0;
    lat       = 0;
    ready_low = (ready === 1'b0) ? 1 : 0;
    while (done !== 1'b1 && lat < 20) begin
      if (inject && lat == 3) begin
        start        = 1'b1;
        multiplicand = W'(3);
        multiplier   = W'(3);
      end
      if (inject && lat == 5) start = 1'b0;
      if (lat == 4) check("product_hold", product, prev_product);
      tick();
      lat++;
      if (ready === 1'b0) ready_low++;
    end
    check("latency", lat, W);
    check("product", product, exp_p);
    prev_product = exp_p;
    tick();
    if (ready === 1'b0) ready_low++;
    check("ready_low_cycles", ready_low, W + 1);
    check("ready_after", ready, 1);
    check("done_after", done, 0);
    $display("op %0d x %0d -> product %0d (expected %0d) latency %0d", a, b, product, exp_p, lat);
  endtask

  initial begin
    int dones;
    int gap;
    reset        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // Reset held across edges, then released with start low.
    tick(); tick(); tick();
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    reset = 1'b1;
    tick(); tick();
    check("post_rst_ready", ready, 1);
    check("post_rst_done", done, 0);
    check("post_rst_product", product, 0);

    // Basic and corner operands.
    run_op(13, 11, 1'b0);
    run_op(255, 255, 1'b0);
    run_op(0, 200, 1'b0);
    run_op(1, 255, 1'b0);

    // Start during RUN is ignored.
    run_op(7, 6, 1'b1);
    count_dones(12, dones);
    check("no_extra_done", dones, 0);
    check("product_kept", product, 42);
    $display("op ignore-start check: extra dones %0d", dones);

    // Asynchronous reset on the 4th RUN cycle.
    multiplicand = W'(200);
    multiplier   = W'(100);
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check("midrun_rst_ready", ready, 1);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_product", product, 0);
    tick();
    reset        = 1'b1;
    prev_product = 0;
    count_dones(12, dones);
    check("midrun_rst_no_done", dones, 0);
    $display("op 200 x 100 aborted by reset: product %0d", product);
    run_op(9, 9, 1'b0);

    // Back-to-back with start held high.
    check("b2b_ready", ready, 1);
    multiplicand = W'(2);
    multiplier   = W'(3);
    start        = 1'b1;
    tick();
    multiplicand = W'(4);
    multiplier   = W'(5);
    gap = 0;
    while (done !== 1'b1 && gap < 30) begin
      tick();
      gap++;
    end
    check("b2b_first_latency", gap, W);
    check("b2b_first_product", product, 6);
    $display("op 2 x 3 -> product %0d (expected 6)", product);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (done !== 1'b1 && gap < 30);
    start = 1'b0;
    check("b2b_gap", gap, W + 2);
    check("b2b_second_product", product, 20);
    $display("op 4 x 5 -> product %0d (expected 20) gap %0d", product, gap);
    count_dones(14, dones);
    check("b2b_no_third", dones, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
